adc_chan_scheduler: RTL and testbench

ADC_CHAN_SCHEDULER -- requirements
Module: adc_chan_scheduler

---
 rtl/adc_chan_scheduler.sv | 133 +++++++++++++
 tb/tb_adc_chan_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_chan_scheduler.sv
// adc_chan_scheduler: round-robin scheduler sharing one ADC converter among NUM_CH channel enable FSMs.
// Optional feature macro: ADC_SCHED_TIMEOUT_EN enables the PWR_UP/PWR_DN timeout and the sticky tmo_err flag.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   sched_en          scheduler enable; low forces a graceful power-down then IDLE
//   req               per-channel level service request
//   ng_active         abort; the active channel is powered down immediately
//   cfg_dwell         CONVERT duration in cycles (0 behaves as 1)
//   cfg_tmo           PWR_UP/PWR_DN cycle limit (timeout build only)
//   chan_powered_up   per-channel powered-up status
//   chan_powered_dn   per-channel powered-down status
//   err_clr           clears tmo_err (timeout build only)
//   chan_enable       one-hot or zero enable to the channel FSMs
//   grant_id          index of the channel being serviced
//   busy              high whenever the scheduler is not IDLE
//   conv_strobe       one-cycle pulse on normal CONVERT completion
//   tmo_err           sticky timeout flag
module adc_chan_scheduler #(
    parameter int NUM_CH = 4,
    parameter int TMO_W  = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sched_en,
    input  logic [NUM_CH-1:0]         req,
    input  logic                      ng_active,
    input  logic [7:0]                cfg_dwell,
    input  logic [TMO_W-1:0]          cfg_tmo,
    input  logic [NUM_CH-1:0]         chan_powered_up,
    input  logic [NUM_CH-1:0]         chan_powered_dn,
    input  logic                      err_clr,
    output logic [NUM_CH-1:0]         chan_enable,
    output logic [$clog2(NUM_CH)-1:0] grant_id,
    output logic                      busy,
    output logic                      conv_strobe,
    output logic                      tmo_err
);
    localparam int GW = $clog2(NUM_CH);

    typedef enum logic [1:0] {IDLE, PWR_UP, CONVERT, PWR_DN} state_t;

    state_t           state, state_nx;
    logic [TMO_W-1:0] cnt;
    logic [GW-1:0]    last_grant, last_nx, grant_nx, rr_pick;
    logic             abort, conv_done, tmo_hit, strobe_nx, tmo_set;
    logic [7:0]       dwell_eff;

    assign abort     = ~sched_en | ng_active;
    assign dwell_eff = cfg_dwell == 8'd0 ? 8'd1 : cfg_dwell;
    // cnt holds (cycles already spent in the state - 1), so +1 gives the cycle count including this one
    assign conv_done = int'(cnt) + 1 >= int'(dwell_eff);

`ifdef ADC_SCHED_TIMEOUT_EN
    assign tmo_hit = int'(cnt) + 1 >= int'(cfg_tmo);
`else
    logic unused_tmo;
    assign tmo_hit    = 1'b0;
    assign unused_tmo = ^{cfg_tmo, err_clr};
`endif

    // Walk offsets from NUM_CH down to 1 so the smallest offset after last_grant wins
    always_comb begin
        rr_pick = last_grant;
        for (int i = NUM_CH; i >= 1; i--)
            if (req[(int'(last_grant) + i) % NUM_CH])
                rr_pick = GW'((int'(last_grant) + i) % NUM_CH);
    end

    always_comb begin
        state_nx  = state;
        grant_nx  = grant_id;
        last_nx   = last_grant;
        strobe_nx = 1'b0;
        tmo_set   = 1'b0;
        case (state)
            IDLE:
                if (sched_en & |req & ~ng_active) begin
                    state_nx = PWR_UP;
                    grant_nx = rr_pick;
                end
            PWR_UP:
                if (abort)
                    state_nx = PWR_DN;
                else if (chan_powered_up[grant_id])
                    state_nx = CONVERT;
                else if (tmo_hit) begin
                    state_nx = PWR_DN;
                    tmo_set  = 1'b1;
                end
            CONVERT:
                if (abort)
                    state_nx = PWR_DN;
                else if (conv_done) begin
                    state_nx  = PWR_DN;
                    strobe_nx = 1'b1;
                end
            PWR_DN:
                if (chan_powered_dn[grant_id] | tmo_hit) begin
                    state_nx = IDLE;
                    last_nx  = grant_id;
                    tmo_set  = ~chan_powered_dn[grant_id];
                end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decision so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            last_grant  <= GW'(NUM_CH - 1);
            grant_id    <= '0;
            chan_enable <= '0;
            busy        <= 1'b0;
            conv_strobe <= 1'b0;
            tmo_err     <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= state_nx != state ? '0 : (&cnt ? cnt : cnt + 1'b1);
            last_grant  <= last_nx;
            grant_id    <= grant_nx;
            chan_enable <= (state_nx == PWR_UP || state_nx == CONVERT) ? NUM_CH'(1) << grant_nx : '0;
            busy        <= state_nx != IDLE;
            conv_strobe <= strobe_nx;
`ifdef ADC_SCHED_TIMEOUT_EN
            tmo_err     <= tmo_set | (tmo_err & ~err_clr);
`else
            tmo_err     <= 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_adc_chan_scheduler.sv
// tb_adc_chan_scheduler: directed and randomized checks of adc_chan_scheduler against a transaction-level model.
module tb_adc_chan_scheduler;
    localparam int N = 4;

    logic         clk = 1'b0, rst = 1'b1, sched_en = 1'b0, ng_active = 1'b0, err_clr = 1'b0;
    logic [N-1:0] req = '0;
    logic [7:0]   cfg_dwell = 8'd0;
    logic [11:0]  cfg_tmo = '1;
    logic [N-1:0] chan_powered_up, chan_powered_dn, chan_enable;
    logic [1:0]   grant_id;
    logic         busy, conv_strobe, tmo_err;

    int   lat = 2;
    logic block_up = 1'b0;
    int   up_cnt[N] = '{default: 0};
    int   dn_cnt[N] = '{default: 1000};
    int   n_assert = 0, n_fail = 0;
    int   last = N - 1;

    adc_chan_scheduler #(.NUM_CH(N), .TMO_W(12)) dut (
        .clk(clk), .rst(rst), .sched_en(sched_en), .req(req), .ng_active(ng_active),
        .cfg_dwell(cfg_dwell), .cfg_tmo(cfg_tmo), .chan_powered_up(chan_powered_up),
        .chan_powered_dn(chan_powered_dn), .err_clr(err_clr), .chan_enable(chan_enable),
        .grant_id(grant_id), .busy(busy), .conv_strobe(conv_strobe), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    // Channel power model: status follows the enable after lat cycles
    always @(posedge clk)
        for (int c = 0; c < N; c++) begin
            up_cnt[c] <= chan_enable[c] ? (up_cnt[c] < 1000 ? up_cnt[c] + 1 : up_cnt[c]) : 0;
            dn_cnt[c] <= chan_enable[c] ? 0 : (dn_cnt[c] < 1000 ? dn_cnt[c] + 1 : dn_cnt[c]);
        end

    always_comb begin
        chan_powered_up = '0;
        chan_powered_dn = '0;
        for (int c = 0; c < N; c++) begin
            chan_powered_up[c] = !block_up && up_cnt[c] >= lat;
            chan_powered_dn[c] = dn_cnt[c] >= lat;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr(input int l, input logic [N-1:0] r);
        for (int i = 1; i <= N; i++)
            if (r[(l + i) % N]) return (l + i) % N;
        return l;
    endfunction

    task automatic wait_enable(input string tag);
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (chan_enable != 0) begin ok = 1; break; end
        end
        check({tag, "_enable_seen"}, 32'(ok), 1);
    endtask

    task automatic wait_up(input int g, input string tag);
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            if (chan_powered_up[g]) begin ok = 1; break; end
            @(negedge clk);
        end
        check({tag, "_up_seen"}, 32'(ok), 1);
    endtask

    task automatic wait_idle(input string tag, output int strobes);
        bit ok = 0;
        strobes = 0;
        for (int i = 0; i < 200; i++) begin
            if (conv_strobe) strobes++;
            if (!busy) begin ok = 1; break; end
            @(negedge clk);
        end
        check({tag, "_idle_seen"}, 32'(ok), 1);
    endtask

    task automatic serve(input logic [N-1:0] r, input logic [7:0] dw, input string tag);
        int  g, conv = 0, strobes = 0, bad = 0;
        bit  done = 0;
        req = r;
        cfg_dwell = dw;
        g = rr(last, r);
        wait_enable(tag);
        check({tag, "_grant"}, 32'(grant_id), 32'(g));
        check({tag, "_onehot"}, 32'(chan_enable), 32'(1 << g));
        for (int i = 0; i < 400; i++) begin
            if ($countones(chan_enable) > 1) bad++;
            if (chan_enable[g] && chan_powered_up[g]) conv++;
            if (conv_strobe) begin
                strobes++;
                if (chan_enable != 0) bad++;
            end
            if (!busy) begin done = 1; break; end
            @(negedge clk);
        end
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_conv_cycles"}, 32'(conv), 32'((dw == 0 ? 1 : int'(dw)) + 1));
        check({tag, "_strobes"}, 32'(strobes), 1);
        check({tag, "_enable_shape"}, 32'(bad), 0);
        last = g;
        req = '0;
    endtask

    initial begin
        int g, s, up_cycles;
        repeat (3) @(negedge clk);
        check("rst_enable", 32'(chan_enable), 0);
        check("rst_grant", 32'(grant_id), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_strobe", 32'(conv_strobe), 0);
        check("rst_tmo", 32'(tmo_err), 0);
        rst = 1'b0;
        sched_en = 1'b1;

        lat = 2;
        for (int k = 0; k < 5; k++) serve(4'b1111, 8'd3, "rr_all");
        serve(4'b0100, 8'd0, "dwell0");
        check("dwell0_last", 32'(last), 2);

        for (int k = 0; k < 12; k++) begin
            lat = $urandom_range(1, 4);
            serve(4'($urandom_range(1, 15)), 8'($urandom_range(0, 6)), "rand");
        end
        lat = 2;

        req = 4'b0001;
        cfg_dwell = 8'd10;
        g = rr(last, req);
        wait_enable("abort");
        req = '0;
        wait_up(g, "abort");
        @(negedge clk);
        @(negedge clk);
        ng_active = 1'b1;
        @(negedge clk);
        check("abort_enable", 32'(chan_enable), 0);
        check("abort_strobe", 32'(conv_strobe), 0);
        check("abort_busy", 32'(busy), 1);
        ng_active = 1'b0;
        wait_idle("abort", s);
        check("abort_no_strobe", 32'(s), 0);
        last = g;

        req = 4'b0010;
        cfg_dwell = 8'd3;
        g = rr(last, req);
        wait_enable("sched_off");
        wait_up(g, "sched_off");
        sched_en = 1'b0;
        @(negedge clk);
        check("sched_off_enable", 32'(chan_enable), 0);
        check("sched_off_busy", 32'(busy), 1);
        wait_idle("sched_off", s);
        check("sched_off_no_strobe", 32'(s), 0);
        sched_en = 1'b1;
        req = '0;
        last = g;

        req = 4'b0100;
        cfg_dwell = 8'd10;
        g = rr(last, req);
        wait_enable("mid_rst");
        wait_up(g, "mid_rst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_enable", 32'(chan_enable), 0);
        check("mid_rst_grant", 32'(grant_id), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_strobe", 32'(conv_strobe), 0);
        check("mid_rst_tmo", 32'(tmo_err), 0);
        rst = 1'b0;
        last = N - 1;
        serve(4'b1111, 8'd2, "post_rst");
        check("post_rst_first", 32'(last), 0);

`ifdef ADC_SCHED_TIMEOUT_EN
        block_up = 1'b1;
        cfg_tmo = 12'd20;
        req = 4'b0010;
        g = rr(last, req);
        wait_enable("tmo");
        req = '0;
        up_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            if (chan_enable == 0) break;
            up_cycles++;
            @(negedge clk);
        end
        check("tmo_up_cycles", 32'(up_cycles), 20);
        check("tmo_set", 32'(tmo_err), 1);
        check("tmo_busy", 32'(busy), 1);
        wait_idle("tmo", s);
        check("tmo_sticky", 32'(tmo_err), 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("tmo_cleared", 32'(tmo_err), 0);
        block_up = 1'b0;
        cfg_tmo = '1;
        last = g;
`else
        up_cycles = 0;
        check("tmo_tied_low", 32'(tmo_err), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
